// File: rtl/csr_apb_regblock.sv
// csr_apb_regblock: parametrised CSR register block behind an APB slave port.
// Each register bit is software RW, W1C or RO (chosen by parameter masks).
// Hardware has a per-bit next/we update path that wins over software on the same edge.
// The APB side supports wait states, byte strobes and an error response.
// irq is the OR of all set W1C bits.
module csr_apb_regblock #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] SW_WR_MASK = '1,
  parameter logic [NUM_REGS*DATA_W-1:0] W1C_MASK = '0,
  parameter int WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_psel,
  input  logic                         i_penable,
  input  logic                         i_pwrite,
  input  logic [ADDR_W-1:0]            i_paddr,
  input  logic [DATA_W-1:0]            i_pwdata,
  input  logic [DATA_W/8-1:0]          i_pstrb,
  output logic [DATA_W-1:0]            o_prdata,
  output logic                         o_pready,
  output logic                         o_pslverr,
  input  logic [NUM_REGS*DATA_W-1:0]   i_hw_next,
  input  logic [NUM_REGS*DATA_W-1:0]   i_hw_we,
  output logic [NUM_REGS*DATA_W-1:0]   o_hw_value,
  output logic [NUM_REGS-1:0]          o_sw_wr_pulse,
  output logic [NUM_REGS-1:0]          o_sw_rd_pulse,
  output logic                         o_irq
);

  localparam int TOT_W  = NUM_REGS * DATA_W;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int NLANES = DATA_W / 8;

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t              r_state;
  logic [1:0]          r_wcnt;
  logic [TOT_W-1:0]    r_regs;
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic [NUM_REGS-1:0] r_rd_pulse;

  logic [IDX_W-1:0]    w_idx;
  logic                w_err;
  logic                w_pready;
  logic                w_done;
  logic                w_wr_commit;
  logic                w_rd_done;
  logic [NUM_REGS-1:0] w_hit;
  logic [DATA_W-1:0]   w_lane_mask;
  logic [DATA_W-1:0]   w_rd_mux;
  logic [TOT_W-1:0]    w_regs_next;

  // Word index from the byte address; misaligned or out-of-range addresses are errors.
  assign w_idx = i_paddr[ADDR_W-1:2];
  assign w_err = (i_paddr[1:0] != 2'b00) || (int'(w_idx) >= NUM_REGS);

  // pready is a decode of the registered FSM state, so completion is visible in the same cycle.
  assign w_pready    = (r_state == ST_ACCESS) && (r_wcnt == 2'(WAIT_STATES));
  assign w_done      = w_pready && i_psel && i_penable;
  assign w_wr_commit = w_done && i_pwrite && !w_err;
  assign w_rd_done   = w_done && !i_pwrite && !w_err;

  assign o_pready  = w_pready;
  assign o_pslverr = w_pready && w_err;
  assign o_prdata  = (w_pready && !i_pwrite && !w_err) ? w_rd_mux : '0;

  assign o_hw_value    = r_regs;
  assign o_sw_wr_pulse = r_wr_pulse;
  assign o_sw_rd_pulse = r_rd_pulse;
  assign o_irq         = |(r_regs & W1C_MASK);

  // Expand byte strobes into a per-bit write mask.
  generate
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
      assign w_lane_mask[gi*8 +: 8] = {8{i_pstrb[gi]}};
    end
  endgenerate

  // Per-register next-state: hardware write enable first, then software RW / W1C, else hold.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [DATA_W-1:0] W1C_R = W1C_MASK[gi*DATA_W +: DATA_W];
      localparam logic [DATA_W-1:0] RW_R  = SW_WR_MASK[gi*DATA_W +: DATA_W] & ~W1C_R;

      logic [DATA_W-1:0] w_cur;
      logic [DATA_W-1:0] w_sw_en;
      logic [DATA_W-1:0] w_rw;
      logic [DATA_W-1:0] w_clr;
      logic [DATA_W-1:0] w_sw_val;
      logic [DATA_W-1:0] w_we;

      assign w_hit[gi] = (w_idx == IDX_W'(gi));
      assign w_cur     = r_regs[gi*DATA_W +: DATA_W];
      assign w_we      = i_hw_we[gi*DATA_W +: DATA_W];
      assign w_sw_en   = {DATA_W{w_wr_commit && w_hit[gi]}} & w_lane_mask;
      assign w_rw      = w_sw_en & RW_R;
      assign w_clr     = w_sw_en & W1C_R & i_pwdata;
      assign w_sw_val  = (w_rw & i_pwdata) | (~w_rw & ~w_clr & w_cur);
      assign w_regs_next[gi*DATA_W +: DATA_W] =
          (w_we & i_hw_next[gi*DATA_W +: DATA_W]) | (~w_we & w_sw_val);
    end
  endgenerate

  // Read data mux over the decoded register index.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_hit[i]) w_rd_mux = r_regs[i*DATA_W +: DATA_W];
    end
  end

  // Register storage: reload reset values, otherwise take the merged HW/SW next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_regs <= RESET_VAL;
    else     r_regs <= w_regs_next;
  end

  // APB FSM with wait counter and one-cycle access pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wcnt     <= 2'd0;
      r_wr_pulse <= '0;
      r_rd_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      r_rd_pulse <= '0;
      case (r_state)
        ST_IDLE: begin
          if (i_psel && !i_penable) begin
            r_state <= ST_ACCESS;
            r_wcnt  <= 2'd0;
          end
        end
        ST_ACCESS: begin
          if (!i_psel) begin
            // Master abandoned the transfer: nothing is committed.
            r_state <= ST_IDLE;
          end else if (w_pready) begin
            r_state    <= ST_IDLE;
            r_wr_pulse <= w_wr_commit ? w_hit : '0;
            r_rd_pulse <= w_rd_done ? w_hit : '0;
          end else begin
            r_wcnt <= r_wcnt + 2'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
